// File: rtl/rect_draw_scheduler_if.sv
// rtl/rect_draw_scheduler_if.sv - client request / pixel stream bundle for the rectangle fill scheduler
interface rect_draw_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*10-1:0] req_x;
    logic [NREQ*9-1:0]  req_y;
    logic [NREQ*10-1:0] req_w;
    logic [NREQ*9-1:0]  req_h;
    logic [NREQ*3-1:0]  req_colour;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [9:0]         out_x;
    logic [8:0]         out_y;
    logic [2:0]         out_colour;
    logic               plot;
    logic               done;
    logic [IDW-1:0]     done_id;

    modport master (
        output req, req_x, req_y, req_w, req_h, req_colour,
        input  gnt, busy, out_x, out_y, out_colour, plot, done, done_id
    );

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_colour,
        output gnt, busy, out_x, out_y, out_colour, plot, done, done_id
    );
endinterface

// File: rtl/rect_draw_scheduler.sv
// rtl/rect_draw_scheduler.sv - round-robin shared rectangle fill engine, one pixel per clock; optional CLIP_EN
module rect_draw_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input logic                clock,
    input logic                resetn,
    rect_draw_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FINISH} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;

    logic [9:0]     sel_x, sel_w;
    logic [8:0]     sel_y, sel_h;
    logic [2:0]     sel_c;

    logic [9:0]     jx, jw, cx;
    logic [8:0]     jy, jh, cy;
    logic [2:0]     jc;
    logic [IDW-1:0] jid;
    logic           pix_on;

    // Search starts at rr_ptr, which already holds last_grant+1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(rr_ptr) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_w = '0;
        sel_h = '0;
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                sel_x = bus.req_x[i*10 +: 10];
                sel_y = bus.req_y[i*9 +: 9];
                sel_w = bus.req_w[i*10 +: 10];
                sel_h = bus.req_h[i*9 +: 9];
                sel_c = bus.req_colour[i*3 +: 3];
            end
        end
    end

`ifdef CLIP_EN
    logic [10:0] true_x;
    logic [9:0]  true_y;
    assign true_x = {1'b0, jx} + {1'b0, cx};
    assign true_y = {1'b0, jy} + {1'b0, cy};
    assign pix_on = (true_x < 11'd640) && (true_y < 10'd480);
`else
    assign pix_on = 1'b1;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            jx             <= '0;
            jy             <= '0;
            jw             <= '0;
            jh             <= '0;
            jc             <= '0;
            jid            <= '0;
            cx             <= '0;
            cy             <= '0;
            bus.gnt        <= '0;
            bus.busy       <= 1'b0;
            bus.out_x      <= '0;
            bus.out_y      <= '0;
            bus.out_colour <= '0;
            bus.plot       <= 1'b0;
            bus.done       <= 1'b0;
            bus.done_id    <= '0;
        end else begin
            bus.gnt  <= '0;
            bus.done <= 1'b0;
            bus.plot <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        bus.gnt  <= NREQ'(1) << win;
                        bus.busy <= 1'b1;
                        rr_ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                        jx       <= sel_x;
                        jy       <= sel_y;
                        jw       <= sel_w;
                        jh       <= sel_h;
                        jc       <= sel_c;
                        jid      <= win;
                        cx       <= '0;
                        cy       <= '0;
                        // Zero-area jobs skip the scan but still report completion.
                        state    <= (sel_w != '0 && sel_h != '0) ? S_DRAW : S_FINISH;
                    end
                end
                S_DRAW: begin
                    bus.plot <= pix_on;
                    if (pix_on) begin
                        bus.out_x      <= jx + cx;
                        bus.out_y      <= jy + cy;
                        bus.out_colour <= jc;
                    end
                    if (cx == jw - 10'd1) begin
                        cx <= '0;
                        if (cy == jh - 9'd1) begin
                            state <= S_FINISH;
                        end else begin
                            cy <= cy + 9'd1;
                        end
                    end else begin
                        cx <= cx + 10'd1;
                    end
                end
                S_FINISH: begin
                    bus.done    <= 1'b1;
                    bus.done_id <= jid;
                    bus.busy    <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
